pc_disparo: RTL and testbench

//  Opponent (PC) shooter: the counterpart of the player-shot path. When it is the PC's turn,

---
 rtl/batalla_pkg.sv | 27 ++
 rtl/pc_lfsr.sv | 25 ++
 rtl/pc_disparo.sv | 185 ++++++++++++++++++
 tb/tb_pc_disparo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/batalla_pkg.sv
// Shared board encodings, board types and PC-shooter FSM states for the
// battleship game datapath.
package batalla_pkg;

    localparam int BOARD_N = 5;

    typedef logic [2:0] cell_t;
    typedef cell_t board_t [BOARD_N][BOARD_N];

    localparam cell_t WATER = 3'b001;
    localparam cell_t SHIP  = 3'b010;
    localparam cell_t NHIT  = 3'b100;
    localparam cell_t HIT   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_THINK,
        S_PICK,
        S_FIRE,
        S_DONE
    } pc_state_t;

    function automatic logic is_shot(input cell_t c);
        return (c == HIT) || (c == NHIT);
    endfunction

endpackage

// File: rtl/pc_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise the
// PC's starting target cell.
module pc_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= SEED;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pc_disparo.sv
// PC shooter: on its turn picks a random not-yet-shot cell of the player's
// board, records HIT/NHIT in a registered copy and hands the turn back.
module pc_disparo
    import batalla_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 4,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       turno_pc,
    input  board_t     player_board,
    output board_t     updated_player_board,
    output logic [2:0] shot_x,
    output logic [2:0] shot_y,
    output logic       shot_valid,
    output logic       hit,
    output logic       no_target,
    output logic       busy,
    output logic       fin_turno
);

    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DELAY_CYCLES - 1);

    pc_state_t   state_q, state_d;
    logic        turno_q, turno_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [4:0]  pcnt_q, pcnt_d;
    logic [2:0]  x_q, x_d, y_q, y_d;
    logic [2:0]  shot_x_q, shot_x_d, shot_y_q, shot_y_d;
    logic        shot_valid_q, shot_valid_d;
    logic        hit_q, hit_d;
    logic        no_target_q, no_target_d;
    logic        busy_q, busy_d;
    logic        fin_turno_q, fin_turno_d;
    board_t      board_q, board_d;

    logic [7:0]  lfsr;
    logic [4:0]  idx;
    logic [2:0]  x_start, y_start, x_next, y_next;
    cell_t       cur_cell;
    logic        unused_lfsr;

    pc_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign unused_lfsr = ^lfsr[7:5];

    // Fold the 5-bit random value into 0..24, then split into row/column.
    always_comb begin
        idx      = (lfsr[4:0] >= 5'd25) ? (lfsr[4:0] - 5'd25) : lfsr[4:0];
        x_start  = 3'(idx / 5'd5);
        y_start  = 3'(idx % 5'd5);
        cur_cell = board_q[x_q][y_q];
        if (y_q == 3'd4) begin
            y_next = 3'd0;
            x_next = (x_q == 3'd4) ? 3'd0 : x_q + 3'd1;
        end else begin
            y_next = y_q + 3'd1;
            x_next = x_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        turno_d      = turno_pc;
        dcnt_d       = dcnt_q;
        pcnt_d       = pcnt_q;
        x_d          = x_q;
        y_d          = y_q;
        shot_x_d     = shot_x_q;
        shot_y_d     = shot_y_q;
        shot_valid_d = 1'b0;
        hit_d        = hit_q;
        no_target_d  = no_target_q;
        fin_turno_d  = 1'b0;
        board_d      = board_q;

        case (state_q)
            S_IDLE: begin
                if (turno_pc && !turno_q) begin
                    board_d     = player_board;
                    no_target_d = 1'b0;
                    dcnt_d      = '0;
                    state_d     = S_THINK;
                end
            end
            S_THINK: begin
                if (!turno_pc) begin
                    state_d = S_IDLE;
                end else if (dcnt_q == DLAST) begin
                    x_d     = x_start;
                    y_d     = y_start;
                    pcnt_d  = 5'd0;
                    state_d = S_PICK;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_PICK: begin
                if (!turno_pc) begin
                    state_d = S_IDLE;
                end else if (!is_shot(cur_cell)) begin
                    state_d = S_FIRE;
                end else if (pcnt_q == 5'd24) begin
                    // Whole board walked without finding an unshot cell.
                    no_target_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    x_d    = x_next;
                    y_d    = y_next;
                    pcnt_d = pcnt_q + 5'd1;
                end
            end
            S_FIRE: begin
                if (cur_cell == SHIP) begin
                    board_d[x_q][y_q] = HIT;
                    hit_d             = 1'b1;
                end else begin
                    board_d[x_q][y_q] = NHIT;
                    hit_d             = 1'b0;
                end
                shot_x_d     = x_q;
                shot_y_d     = y_q;
                shot_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                fin_turno_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            turno_q      <= 1'b0;
            dcnt_q       <= '0;
            pcnt_q       <= 5'd0;
            x_q          <= 3'd0;
            y_q          <= 3'd0;
            shot_x_q     <= 3'd0;
            shot_y_q     <= 3'd0;
            shot_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            no_target_q  <= 1'b0;
            busy_q       <= 1'b0;
            fin_turno_q  <= 1'b0;
            board_q      <= '{default: WATER};
        end else begin
            state_q      <= state_d;
            turno_q      <= turno_d;
            dcnt_q       <= dcnt_d;
            pcnt_q       <= pcnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            shot_x_q     <= shot_x_d;
            shot_y_q     <= shot_y_d;
            shot_valid_q <= shot_valid_d;
            hit_q        <= hit_d;
            no_target_q  <= no_target_d;
            busy_q       <= busy_d;
            fin_turno_q  <= fin_turno_d;
            board_q      <= board_d;
        end
    end

    assign updated_player_board = board_q;
    assign shot_x               = shot_x_q;
    assign shot_y               = shot_y_q;
    assign shot_valid           = shot_valid_q;
    assign hit                  = hit_q;
    assign no_target            = no_target_q;
    assign busy                 = busy_q;
    assign fin_turno            = fin_turno_q;

endmodule

// File: tb/tb_pc_disparo.sv
// Scoreboard bench for pc_disparo: stimulus pushes expected shot/finish
// events, a negedge monitor pops and compares them against the outputs.
module tb_pc_disparo;
    import batalla_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       turno_pc = 1'b0;
    board_t     pb, ub;
    logic [2:0] sx, sy;
    logic       sv, hit, nt, busy, fin;

    pc_disparo #(.DELAY_CYCLES(D), .LFSR_SEED(8'hA5)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .turno_pc             (turno_pc),
        .player_board         (pb),
        .updated_player_board (ub),
        .shot_x               (sx),
        .shot_y               (sy),
        .shot_valid           (sv),
        .hit                  (hit),
        .no_target            (nt),
        .busy                 (busy),
        .fin_turno            (fin)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5, runs every clock.
    logic [7:0] m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= 8'hA5;
        else        m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    typedef struct packed {
        logic       shot;
        logic [2:0] x;
        logic [2:0] y;
        logic       hit;
        logic       nt;
    } exp_t;

    exp_t   q[$];
    board_t exp_board;
    int     log_x[$], log_y[$];
    int     n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [74:0] flat(input board_t b);
        logic [74:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r[(i*5+j)*3 +: 3] = b[i][j];
        return r;
    endfunction

    function automatic board_t fill(input cell_t c);
        board_t b;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                b[i][j] = c;
        return b;
    endfunction

    // Row-major walk from idx, wrapping 24 -> 0, stopping on the first unshot cell.
    function automatic void walk(input board_t b, input int idx, output int tx, output int ty,
                                 output int pr, output bit found);
        int x, y;
        x = idx / 5; y = idx % 5;
        found = 0; tx = 0; ty = 0; pr = 25;
        for (int k = 0; k < 25; k++) begin
            if (b[x][y] != 3'b111 && b[x][y] != 3'b100) begin
                found = 1; tx = x; ty = y; pr = k;
                return;
            end
            y++;
            if (y == 5) begin y = 0; x = (x + 1) % 5; end
        end
    endfunction

    // Monitor
    exp_t e;
    logic prev_sv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sv = 1'b0;
        end else begin
            if (sv) begin
                chk("shot_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("event_is_shot", e.shot, 1'b1);
                    chk("shot_x", sx, e.x);
                    chk("shot_y", sy, e.y);
                    chk("hit", hit, e.hit);
                    chk("shot_cell", ub[sx][sy], e.hit ? 3'b111 : 3'b100);
                    log_x.push_back(int'(sx));
                    log_y.push_back(int'(sy));
                end
            end
            if (fin) begin
                chk("fin_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("event_is_fin", e.shot, 1'b0);
                    chk("no_target", nt, e.nt);
                    chk("fin_after_shot", prev_sv, !e.nt);
                    chk("board_at_fin", flat(ub), flat(exp_board));
                end
            end
            prev_sv = sv;
        end
    end

    task automatic do_reset();
        turno_pc = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_turn(input board_t b, output int cyc);
        int idx, tx, ty, pr, lat;
        bit found;
        exp_t t;
        board_t eb;
        pb = b;
        turno_pc = 1'b1;
        @(posedge clk);
        repeat (D - 1) @(posedge clk);
        #1;
        idx = int'(m[4:0]);
        if (idx >= 25) idx -= 25;
        walk(b, idx, tx, ty, pr, found);
        eb = b;
        if (found) begin
            eb[tx][ty] = (b[tx][ty] == SHIP) ? 3'b111 : 3'b100;
            t.shot = 1'b1; t.x = tx[2:0]; t.y = ty[2:0];
            t.hit = (b[tx][ty] == SHIP); t.nt = 1'b0;
            q.push_back(t);
            lat = D + pr + 4;
        end else begin
            lat = D + 27;
        end
        exp_board = eb;
        t.shot = 1'b0; t.x = 3'd0; t.y = 3'd0; t.hit = 1'b0; t.nt = !found;
        q.push_back(t);
        cyc = D;
        while (!fin && cyc < 60) begin
            @(posedge clk); cyc++; #1;
        end
        chk("latency", cyc, lat);
        turno_pc = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        board_t b;
        int cyc;
        int seq_x[$], seq_y[$];
        int cnt [5][5];

        #1;
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_shot_valid", sv, 1'b0);
        chk("rst_fin", fin, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_no_target", nt, 1'b0);
        chk("rst_xy", {sx, sy}, 6'd0);
        chk("rst_board", flat(ub), flat(fill(3'b001)));

        // Only (0,0) is unshot water
        b = fill(3'b100); b[0][0] = 3'b001;
        run_turn(b, cyc);
        chk("t3_cell00", ub[0][0], 3'b100);
        chk("t3_hit", hit, 1'b0);
        chk("t3_lat_max", cyc <= 32, 1'b1);

        // Fully shot board
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                b[i][j] = ((i + j) % 2 == 0) ? 3'b111 : 3'b100;
        run_turn(b, cyc);
        chk("t2_no_target", nt, 1'b1);
        chk("t2_board", flat(ub), flat(b));

        // Abort two cycles into THINK
        b = fill(3'b001); b[1][1] = SHIP;
        pb = b; turno_pc = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 turno_pc = 1'b0;
        @(posedge clk); #1;
        chk("t4_busy", busy, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_board_snapshot", flat(ub), flat(b));
        chk("t4_fin", fin, 1'b0);

        // Single ship at (3,2)
        b = fill(3'b100); b[3][2] = SHIP;
        run_turn(b, cyc);
        chk("t1_x", sx, 3'd3);
        chk("t1_y", sy, 3'd2);
        chk("t1_hit", hit, 1'b1);
        chk("t1_cell", ub[3][2], 3'b111);

        // Reset while in PICK
        b = fill(3'b100); b[0][0] = 3'b001;
        pb = b; turno_pc = 1'b1;
        @(posedge clk);
        repeat (D) @(posedge clk);
        #1;
        chk("t5_busy_before", busy, 1'b1);
        rst_n = 1'b0; turno_pc = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_outs", {sv, fin, hit, nt, sx, sy}, 10'd0);
        chk("t5_board", flat(ub), flat(fill(3'b001)));
        @(posedge clk); #1 rst_n = 1'b1;

        // Two identical 26-turn games on an all-water board
        for (int run = 0; run < 2; run++) begin
            do_reset();
            log_x.delete(); log_y.delete();
            b = fill(3'b001);
            for (int t = 0; t < 26; t++) begin
                run_turn(b, cyc);
                b = exp_board;
            end
            chk("t6_last_no_target", nt, 1'b1);
            chk("t6_shots", log_x.size(), 25);
            if (run == 0) begin
                seq_x = log_x; seq_y = log_y;
            end else begin
                for (int k = 0; k < 25 && k < log_x.size() && k < seq_x.size(); k++) begin
                    chk("t6_repeat_x", log_x[k], seq_x[k]);
                    chk("t6_repeat_y", log_y[k], seq_y[k]);
                end
            end
        end
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                cnt[i][j] = 0;
        for (int k = 0; k < seq_x.size(); k++)
            if (seq_x[k] < 5 && seq_y[k] < 5) cnt[seq_x[k]][seq_y[k]]++;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                chk("t6_cell_once", cnt[i][j], 1);

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
